// File: rtl/eeg_fram_pkg.sv
// Shared constants and FSM state encoding for the FRAM read-side address generator.
// Pure declarations: no latency, no flow control.
package eeg_fram_pkg;

    localparam int ADD_AW_DEF    = 12;
    localparam int DAT_DW_DEF    = 4;
    localparam int LEN_DW_DEF    = 12;
    localparam int OST_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        AGU_IDLE  = 3'b001,
        AGU_ISSUE = 3'b010,
        AGU_DRAIN = 3'b100
    } agu_state_t;

endpackage

// File: rtl/eeg_fram_rd_fifo.sv
// Synchronous FIFO with a registered head word; a push into an empty FIFO is visible next cycle.
// Push is refused only when full with no simultaneous pop; pop follows o_empty / i_pop_rdy.
module eeg_fram_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push_vld,
    input  logic [DW-1:0] i_push_dat,
    output logic          o_full,
    input  logic          i_pop_rdy,
    output logic [DW-1:0] o_pop_dat,
    output logic          o_empty
);

    localparam int PW = $clog2(DEPTH);

    // Head register plus a ring holding at most DEPTH-1 further words.
    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_cnt;
    logic          r_head_vld;
    logic [DW-1:0] r_head_dat;

    logic w_pop;
    logic w_head_load;
    logic w_mem_empty;
    logic w_bypass;
    logic w_mem_wr;
    logic w_mem_rd;

    assign w_pop       = r_head_vld & i_pop_rdy;
    assign w_head_load = ~r_head_vld | w_pop;
    assign w_mem_empty = (r_cnt == '0);
    assign w_bypass    = i_push_vld & w_head_load & w_mem_empty;
    assign w_mem_wr    = i_push_vld & ~w_bypass;
    assign w_mem_rd    = w_head_load & ~w_mem_empty;

    assign o_full    = r_head_vld & (r_cnt == PW'(DEPTH - 1));
    assign o_empty   = ~r_head_vld;
    assign o_pop_dat = r_head_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_head_vld <= 1'b0;
            r_head_dat <= '0;
        end else begin
            if (w_mem_wr) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_mem_rd) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_cnt <= r_cnt + PW'(w_mem_wr) - PW'(w_mem_rd);
            if (w_head_load) begin
                if (!w_mem_empty) begin
                    r_head_vld <= 1'b1;
                    r_head_dat <= r_mem[r_rd_ptr];
                end else if (i_push_vld) begin
                    r_head_vld <= 1'b1;
                    r_head_dat <= i_push_dat;
                end else begin
                    r_head_vld <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_wr) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

endmodule

// File: rtl/eeg_fram_rd_agu.sv
// Per-lane FRAM read address generator: strided addresses out, returned words buffered to OUT.
// First address one cycle after CFG accept; issue stalls on zero credit, FRAM data is never back-pressured.
module eeg_fram_rd_agu
    import eeg_fram_pkg::*;
#(
    parameter int ADD_AW    = ADD_AW_DEF,
    parameter int DAT_DW    = DAT_DW_DEF,
    parameter int LEN_DW    = LEN_DW_DEF,
    parameter int OST_DEPTH = OST_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_is_idle,
    input  logic              i_cfg_vld,
    output logic              o_cfg_rdy,
    input  logic [ADD_AW-1:0] i_cfg_base,
    input  logic [LEN_DW-1:0] i_cfg_len,
    input  logic [ADD_AW-1:0] i_cfg_stride,
    output logic              o_add_vld,
    output logic              o_add_lst,
    input  logic              i_add_rdy,
    output logic [ADD_AW-1:0] o_add_add,
    input  logic              i_dat_vld,
    input  logic              i_dat_lst,
    output logic              o_dat_rdy,
    input  logic [DAT_DW-1:0] i_dat_dat,
    output logic              o_out_vld,
    output logic              o_out_lst,
    input  logic              i_out_rdy,
    output logic [DAT_DW-1:0] o_out_dat,
    output logic              o_err_lst
);

    localparam int CW = $clog2(OST_DEPTH + 1);

    agu_state_t        r_state;
    logic [ADD_AW-1:0] r_stride;
    logic [ADD_AW-1:0] r_add_add;
    logic [LEN_DW-1:0] r_len;
    logic [LEN_DW-1:0] r_issue_cnt;
    logic [LEN_DW-1:0] r_push_cnt;
    logic [CW-1:0]     r_credit;
    logic              r_add_vld;
    logic              r_add_lst;
    logic              r_err_lst;

    logic [CW-1:0]     w_credit_nxt;
    logic              w_add_fire;
    logic              w_out_fire;
    logic              w_push;
    logic              w_lst_exp;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [DAT_DW:0]   w_head;

    assign w_add_fire = r_add_vld & i_add_rdy;
    assign w_out_fire = ~w_fifo_empty & i_out_rdy;
    assign w_lst_exp  = (r_push_cnt == r_len);
    // Credits keep the buffer from overflowing; the full guard only matters if FRAM misbehaves.
    assign w_push     = i_dat_vld & (r_state != AGU_IDLE) & (~w_fifo_full | w_out_fire);

    always_comb begin
        w_credit_nxt = r_credit;
        if (w_add_fire && !w_out_fire) begin
            w_credit_nxt = r_credit - CW'(1);
        end else if (!w_add_fire && w_out_fire) begin
            w_credit_nxt = r_credit + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= AGU_IDLE;
            r_stride    <= '0;
            r_add_add   <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_push_cnt  <= '0;
            r_credit    <= CW'(OST_DEPTH);
            r_add_vld   <= 1'b0;
            r_add_lst   <= 1'b0;
            r_err_lst   <= 1'b0;
        end else begin
            r_credit <= w_credit_nxt;
            if (w_push) begin
                r_push_cnt <= r_push_cnt + LEN_DW'(1);
                if (i_dat_lst != w_lst_exp) begin
                    r_err_lst <= 1'b1;
                end
            end
            unique case (r_state)
                AGU_IDLE: begin
                    // A stray FRAM word in the job-accept cycle still flags the error.
                    r_err_lst <= i_dat_vld | (r_err_lst & ~i_cfg_vld);
                    if (i_cfg_vld) begin
                        r_state     <= AGU_ISSUE;
                        r_add_add   <= i_cfg_base;
                        r_stride    <= i_cfg_stride;
                        r_len       <= i_cfg_len;
                        r_issue_cnt <= '0;
                        r_push_cnt  <= '0;
                        r_add_vld   <= (w_credit_nxt != '0);
                        r_add_lst   <= (i_cfg_len == '0);
                    end
                end
                AGU_ISSUE: begin
                    if (w_add_fire) begin
                        r_add_add   <= r_add_add + r_stride;
                        r_issue_cnt <= r_issue_cnt + LEN_DW'(1);
                        if (r_add_lst) begin
                            r_state   <= AGU_DRAIN;
                            r_add_vld <= 1'b0;
                            r_add_lst <= 1'b0;
                        end else begin
                            r_add_vld <= (w_credit_nxt != '0);
                            r_add_lst <= ((r_issue_cnt + LEN_DW'(1)) == r_len);
                        end
                    end else begin
                        r_add_vld <= (w_credit_nxt != '0);
                    end
                end
                AGU_DRAIN: begin
                    if (w_out_fire && o_out_lst) begin
                        r_state <= AGU_IDLE;
                    end
                end
                default: begin
                    r_state <= AGU_IDLE;
                end
            endcase
        end
    end

    // The last-word tag travels with the data so OUT_LST comes straight from the head register.
    eeg_fram_rd_fifo #(
        .DEPTH (OST_DEPTH),
        .DW    (DAT_DW + 1)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push_vld (w_push),
        .i_push_dat ({w_lst_exp, i_dat_dat}),
        .o_full     (w_fifo_full),
        .i_pop_rdy  (i_out_rdy),
        .o_pop_dat  (w_head),
        .o_empty    (w_fifo_empty)
    );

    assign o_is_idle = (r_state == AGU_IDLE);
    assign o_cfg_rdy = (r_state == AGU_IDLE);
    assign o_add_vld = r_add_vld;
    assign o_add_lst = r_add_lst;
    assign o_add_add = r_add_add;
    assign o_dat_rdy = 1'b1;
    assign o_out_vld = ~w_fifo_empty;
    assign o_out_lst = w_head[DAT_DW] & ~w_fifo_empty;
    assign o_out_dat = w_head[DAT_DW-1:0];
    assign o_err_lst = r_err_lst;

endmodule

// File: tb/tb_eeg_fram_rd_agu.sv
// Directed job table plus a mid-job reset sequence for the FRAM read address generator.
module tb_eeg_fram_rd_agu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        o_is_idle, o_cfg_rdy;
    logic        i_cfg_vld;
    logic [11:0] i_cfg_base, i_cfg_stride, i_cfg_len;
    logic        o_add_vld, o_add_lst, i_add_rdy;
    logic [11:0] o_add_add;
    logic        i_dat_vld, i_dat_lst, o_dat_rdy;
    logic [3:0]  i_dat_dat;
    logic        o_out_vld, o_out_lst, i_out_rdy;
    logic [3:0]  o_out_dat;
    logic        o_err_lst;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    eeg_fram_rd_agu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .o_is_idle    (o_is_idle),
        .i_cfg_vld    (i_cfg_vld),
        .o_cfg_rdy    (o_cfg_rdy),
        .i_cfg_base   (i_cfg_base),
        .i_cfg_len    (i_cfg_len),
        .i_cfg_stride (i_cfg_stride),
        .o_add_vld    (o_add_vld),
        .o_add_lst    (o_add_lst),
        .i_add_rdy    (i_add_rdy),
        .o_add_add    (o_add_add),
        .i_dat_vld    (i_dat_vld),
        .i_dat_lst    (i_dat_lst),
        .o_dat_rdy    (o_dat_rdy),
        .i_dat_dat    (i_dat_dat),
        .o_out_vld    (o_out_vld),
        .o_out_lst    (o_out_lst),
        .i_out_rdy    (i_out_rdy),
        .o_out_dat    (o_out_dat),
        .o_err_lst    (o_err_lst)
    );

    typedef struct {
        logic [11:0] base;
        logic [11:0] stride;
        logic [11:0] len;
        int          hold;       // cycles with OUT_RDY low at job start
        int          bad_idx;    // word index where FRAM raises DAT_LST wrongly, -1 for none
        bit          toggle;     // ADD_RDY toggles every cycle
        logic [11:0] exp_last;   // hand-computed final address
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];
    vec_t clean_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] fdat(input logic [11:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8];
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_is_idle"}, o_is_idle, 1);
        check({tag, "_cfg_rdy"}, o_cfg_rdy, 1);
        check({tag, "_add_vld"}, o_add_vld, 0);
        check({tag, "_add_lst"}, o_add_lst, 0);
        check({tag, "_add_add"}, o_add_add, 0);
        check({tag, "_out_vld"}, o_out_vld, 0);
        check({tag, "_out_lst"}, o_out_lst, 0);
        check({tag, "_out_dat"}, o_out_dat, 0);
        check({tag, "_err_lst"}, o_err_lst, 0);
        check({tag, "_dat_rdy"}, o_dat_rdy, 1);
    endtask

    task automatic run_job(input vec_t v);
        logic [11:0] fq[$];
        logic [11:0] a;
        logic [11:0] last_addr = '0;
        logic [11:0] prev_addr = '0;
        bit          prev_wait = 1'b0;
        bit          done = 1'b0;
        int          issue_i = 0;
        int          out_i = 0;
        int          ret_i = 0;
        int          cyc = 0;

        i_dat_vld = 1'b0;
        i_add_rdy = 1'b1;
        i_out_rdy = 1'b1;
        for (int k = 0; k < 20 && !o_cfg_rdy; k++) tick();
        check("cfg_rdy_wait", o_cfg_rdy, 1);
        i_cfg_vld    = 1'b1;
        i_cfg_base   = v.base;
        i_cfg_stride = v.stride;
        i_cfg_len    = v.len;
        tick();
        i_cfg_vld = 1'b0;
        check("first_add_vld", o_add_vld, 1);
        check("err_clr_on_cfg", o_err_lst, 0);
        check("busy_after_cfg", o_is_idle, 0);

        while (!done && cyc < 400) begin
            if (v.hold > 0 && cyc == v.hold) begin
                check("ost_limit_cnt", issue_i, 4);
                check("ost_limit_vld", o_add_vld, 0);
            end
            i_out_rdy = (cyc >= v.hold);
            i_add_rdy = v.toggle ? cyc[0] : 1'b1;
            check("dat_rdy_high", o_dat_rdy, 1);
            if (prev_wait) begin
                check("add_vld_held", o_add_vld, 1);
                check("add_add_held", o_add_add, prev_addr);
            end
            prev_wait = o_add_vld && !i_add_rdy;
            prev_addr = o_add_add;
            if (o_add_vld && i_add_rdy) begin
                a = v.base + v.stride * 12'(issue_i);
                check("add_add", o_add_add, a);
                check("add_lst", o_add_lst, (issue_i == int'(v.len)));
                fq.push_back(o_add_add);
                last_addr = o_add_add;
                issue_i++;
            end
            if (o_out_vld && i_out_rdy) begin
                a = v.base + v.stride * 12'(out_i);
                check("out_dat", o_out_dat, fdat(a));
                check("out_lst", o_out_lst, (out_i == int'(v.len)));
                if (out_i == int'(v.len)) begin
                    check("not_idle_at_last", o_is_idle, 0);
                    done = 1'b1;
                end
                out_i++;
            end
            if (i_dat_vld) ret_i++;
            tick();
            if (fq.size() > 0) begin
                a         = fq.pop_front();
                i_dat_vld = 1'b1;
                i_dat_dat = fdat(a);
                i_dat_lst = (v.bad_idx >= 0) ? (ret_i == v.bad_idx) : (ret_i == int'(v.len));
            end else begin
                i_dat_vld = 1'b0;
            end
            cyc++;
        end
        i_dat_vld = 1'b0;
        check("job_done", done, 1);
        check("idle_after_last", o_is_idle, 1);
        check("cfg_rdy_after_last", o_cfg_rdy, 1);
        check("word_count", out_i, int'(v.len) + 1);
        check("last_addr", last_addr, v.exp_last);
        check("err_lst", o_err_lst, v.exp_err);
        i_out_rdy = 1'b1;
        i_add_rdy = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        i_cfg_vld    = 1'b0;
        i_cfg_base   = '0;
        i_cfg_stride = '0;
        i_cfg_len    = '0;
        i_add_rdy    = 1'b1;
        i_dat_vld    = 1'b0;
        i_dat_lst    = 1'b0;
        i_dat_dat    = '0;
        i_out_rdy    = 1'b1;

        //             base    stride  len     hold bad toggle last    err
        vecs[0] = '{12'h010, 12'h001, 12'd3,  0,  -1, 1'b0, 12'h013, 1'b0};
        vecs[1] = '{12'hFFE, 12'h003, 12'd2,  0,  -1, 1'b0, 12'h004, 1'b0};
        vecs[2] = '{12'h200, 12'h002, 12'd15, 20, -1, 1'b0, 12'h21E, 1'b0};
        vecs[3] = '{12'h123, 12'h005, 12'd0,  0,  -1, 1'b0, 12'h123, 1'b0};
        vecs[4] = '{12'h040, 12'h004, 12'd3,  0,   1, 1'b0, 12'h04C, 1'b1};
        vecs[5] = '{12'h300, 12'h010, 12'd3,  0,  -1, 1'b1, 12'h330, 1'b0};
        clean_vec = '{12'h7F0, 12'h008, 12'd5, 0, -1, 1'b0, 12'h818, 1'b0};

        repeat (2) @(negedge clk);
        check_reset_vals("in_rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_rst");

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i]);
        end

        // Reset with two reads outstanding in FRAM, then a late response.
        i_out_rdy    = 1'b0;
        i_cfg_vld    = 1'b1;
        i_cfg_base   = 12'h400;
        i_cfg_stride = 12'h001;
        i_cfg_len    = 12'd7;
        tick();
        i_cfg_vld = 1'b0;
        tick();
        tick();
        check("pre_rst_add_vld", o_add_vld, 1);
        check("pre_rst_add_add", o_add_add, 12'h402);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(negedge clk);
        rst_n     = 1'b1;
        i_dat_vld = 1'b1;
        i_dat_dat = 4'h4;
        i_dat_lst = 1'b0;
        tick();
        i_dat_vld = 1'b0;
        check("late_dat_err", o_err_lst, 1);
        check("late_dat_dropped", o_out_vld, 0);
        check("late_dat_idle", o_is_idle, 1);
        tick();
        check("late_err_held", o_err_lst, 1);
        i_out_rdy = 1'b1;
        run_job(clean_vec);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eeg_fram_rd_agu.md
Name: eeg_fram_rd_agu

Overview:
- Per-lane read-side neighbour of the FRAM block.
- Generates the strided address stream into one FRAM read-address lane (ETOF_ADD_*) and consumes that lane's returned data (FTOE_DAT_*).
- Forwards returned data to the downstream compute stage through a credit-controlled buffer. Because of the credits, FRAM read data is always accepted (DAT_RDY never low while data is in flight).
- One instance per FRAM lane; the top level instantiates FRAM_NUM_DW copies.

Parameters:
- ADD_AW, 12, FRAM address width; matches FRAM_ADD_AW.
- DAT_DW, 4, data word width; matches FRAM_DAT_DW.
- LEN_DW, 12, transfer-length field width.
- OST_DEPTH, 4, max words outstanding in FRAM plus held in the buffer; power of 2, >=2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- IS_IDLE  out  1  high in IDLE state.
- CFG_VLD  in  1  job request.
- CFG_RDY  out  1  job accept; high only in IDLE.
- CFG_BASE  in  ADD_AW  first address.
- CFG_LEN  in  LEN_DW  word count minus 1.
- CFG_STRIDE  in  ADD_AW  address increment per word.
- ADD_VLD  out  1  to FRAM ETOF_ADD_VLD.
- ADD_LST  out  1  to ETOF_ADD_LST; marks final address.
- ADD_RDY  in  1  from ETOF_ADD_RDY.
- ADD_ADD  out  ADD_AW  to ETOF_ADD_ADD.
- DAT_VLD  in  1  from FTOE_DAT_VLD.
- DAT_LST  in  1  from FTOE_DAT_LST.
- DAT_RDY  out  1  to FTOE_DAT_RDY.
- DAT_DAT  in  DAT_DW  from FTOE_DAT_DAT.
- OUT_VLD  out  1  downstream valid.
- OUT_LST  out  1  last word of job.
- OUT_RDY  in  1  downstream ready.
- OUT_DAT  out  DAT_DW  downstream data.
- ERR_LST  out  1  sticky: DAT_LST mismatch seen.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, IS_IDLE=1, CFG_RDY=1, ADD_VLD=0, ADD_LST=0, ADD_ADD=0, OUT_VLD=0, OUT_LST=0, OUT_DAT=0, ERR_LST=0, DAT_RDY=1, credit=OST_DEPTH, buffer empty, all counters 0.
- Handshakes: transfer occurs when VLD & RDY at a clk edge. VLD/payload are held stable until accepted. VLD never depends combinationally on RDY.
- FSM states:
  - IDLE: CFG_RDY=1. On CFG_VLD, latch BASE/LEN/STRIDE, clear issue and pop counters, clear ERR_LST, go to ISSUE.
  - ISSUE: ADD_VLD = (credit != 0). ADD_ADD = base + issue_cnt*stride, accumulated by adding STRIDE on each accept, mod 2^ADD_AW (wraps silently). ADD_LST = (issue_cnt == LEN). When ADD_LST is accepted, go to DRAIN.
  - DRAIN: ADD_VLD=0. Go to IDLE in the cycle after the OUT transfer with OUT_LST=1.
- Latency:
  - First ADD_VLD appears the cycle after the CFG accept (if credit != 0).
  - Address issue rate is 1 per cycle while ADD_RDY and credit allow.
- Credit accounting:
  - credit = OST_DEPTH minus (addresses accepted but not yet popped at OUT).
  - Decrement on ADD accept; increment on OUT accept.
  - Both in the same cycle: credit unchanged.
  - credit=0 forces ADD_VLD=0. ADD_VLD must not drop while waiting for ADD_RDY; it only rises when credit != 0 and credit can only rise while waiting.
- Data path:
  - DAT_RDY=1 always. Credits guarantee buffer space for OST_DEPTH words.
  - Each accepted DAT word is written to the buffer FIFO (depth OST_DEPTH, registered output).
  - OUT_VLD rises the cycle after the DAT accept when the buffer was empty. Full throughput, 1 word/cycle, when OUT_RDY=1.
  - Simultaneous push and pop on a full buffer is legal.
- OUT_LST: generated internally, high when pop_cnt == LEN for the head word.
- ERR_LST: set if an accepted DAT_LST disagrees with the internal push_cnt == LEN; held until the next CFG accept.
- DAT_VLD in IDLE: word dropped and ERR_LST set.
- CFG_LEN=0: single-word job, with ADD_LST and OUT_LST on the first word.
- OST_DEPTH=2: still correct at half throughput minimum.
- Reset mid-job: all state cleared immediately (asynchronous). In-flight FRAM responses arriving after reset are treated as DAT_VLD in IDLE.

Decomposition:
- Shared package eeg_fram_pkg:
  - state one-hot localparams AGU_IDLE=3'b001, AGU_ISSUE=3'b010, AGU_DRAIN=3'b100;
  - default width constants for ADD/DAT/LEN.
- Sub-module eeg_fram_rd_fifo: synchronous FIFO.
  - Parameters DEPTH and DW.
  - Ports: push/pop handshake, full/empty.
  - Registered head output.
- This block keeps the FSM, address accumulator, counters, credit logic and ERR_LST.

Test Plan:
- BASE=0x010, STRIDE=1, LEN=3, FRAM returns data 1 cycle after each address, OUT_RDY=1 → ADD_ADD 0x010..0x013, ADD_LST on 0x013; OUT_DAT in order; OUT_LST on the 4th word; IS_IDLE the cycle after.
- BASE=0xFFE, STRIDE=3, LEN=2 → addresses 0xFFE, 0x001, 0x004 (wrap); no ERR_LST.
- LEN=15, OUT_RDY=0 → exactly OST_DEPTH=4 addresses accepted, then ADD_VLD=0, DAT_RDY stays 1, no data lost; after OUT_RDY=1, all 16 words arrive in order.
- LEN=0, BASE=0x123 → single address with ADD_LST=1; single OUT word with OUT_LST=1; CFG_RDY returns high.
- FRAM asserts DAT_LST on word 2 of a 4-word job → ERR_LST=1 and held; cleared by the next CFG accept.
- rst_n low for 1 cycle while in ISSUE with 2 outstanding → all outputs at reset values; late DAT_VLD sets ERR_LST; the next job runs cleanly.
